// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencer for a shared-memory multi-cycle RV32I datapath. Each
//   instruction steps through FETCH, DECODE, an execute state, optional
//   memory access and write-back. Every memory access (and the optional
//   mul/div unit) is handshaked. A wait longer than MEM_TIMEOUT cycles,
//   or an opcode that cannot be decoded, parks the machine in a sticky
//   FAULT state that only reset leaves.
//
// Build option:
//   MULTICYCLE_MULDIV_EN - when defined, R-type with funct7[0]=1 runs
//   through the MULDIV state. When undefined, that encoding faults and
//   muldiv_start is tied low.
//
// Parameters:
//   MEM_TIMEOUT - maximum number of wait cycles on mem_ready/muldiv_done
//                 before FAULT. 0 disables the timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct7_b0   instruction fields held in the IR
//   branch_taken        comparator result for the current branch
//   mem_ready           memory completes the current access this cycle
//   muldiv_done         mul/div result valid
//   pc_write, ir_write  PC load / IR and old_pc load
//   mem_read, mem_write memory requests
//   i_or_d              address select (0 = PC, 1 = ALU register)
//   reg_write, wb_sel   register file write and its source
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   imm_type            immediate format
//   pc_src              next-PC source
//   muldiv_start        one-cycle mul/div start pulse
//   fault               sticky fault flag
//   state               current state encoding (debug)
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       funct7_b0,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_type,
  output logic [1:0] pc_src,
  output logic       muldiv_start,
  output logic       fault,
  output logic [3:0] state
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB       = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_UPPER    = 4'd11,
    S_MULDIV   = 4'd12,
    S_FAULT    = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_waiting;
  logic             w_timeout;
  logic [1:0]       r_wb_sel;
  logic [1:0]       w_wb_sel_nxt;

  // Counter reaching the limit only faults if the handshake did not
  // complete in that same cycle; the next-state logic checks completion
  // first.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT));
  assign state     = r_state;

  always_comb begin
    w_next       = r_state;
    w_wb_sel_nxt = r_wb_sel;
    w_waiting    = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        w_waiting = 1'b1;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
`ifdef MULTICYCLE_MULDIV_EN
          OP_R:                w_next = funct7_b0 ? S_MULDIV : S_EXEC_R;
`else
          OP_R:                w_next = funct7_b0 ? S_FAULT : S_EXEC_R;
`endif
          OP_IMM:              w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:   w_next = S_MEM_ADDR;
          OP_BRANCH:           w_next = S_BRANCH;
          OP_JAL, OP_JALR:     w_next = S_JUMP;
          OP_LUI, OP_AUIPC:    w_next = S_UPPER;
          default:             w_next = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_UPPER: begin
        w_next       = S_WB;
        w_wb_sel_nxt = 2'b00;
      end
      S_MEM_ADDR: w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        w_waiting = 1'b1;
        if (mem_ready) begin
          w_next       = S_WB;
          w_wb_sel_nxt = 2'b01;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_MEM_WR: begin
        w_waiting = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
`ifdef MULTICYCLE_MULDIV_EN
      S_MULDIV: begin
        w_waiting = 1'b1;
        if (muldiv_done) begin
          w_next       = S_WB;
          w_wb_sel_nxt = 2'b00;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
`endif
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wb_sel <= 2'b00;
    end else begin
      r_state  <= w_next;
      r_wb_sel <= w_wb_sel_nxt;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_waiting)    r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MULTICYCLE_MULDIV_EN
  // Set after the first MULDIV cycle so the start pulse lasts one cycle
  // regardless of how the wait counter behaves.
  logic r_md_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_md_busy <= 1'b0;
    else        r_md_busy <= (r_state == S_MULDIV) && (w_next == S_MULDIV);
  end
`else
  logic w_unused_muldiv_done;
  assign w_unused_muldiv_done = muldiv_done;
`endif

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    imm_type     = 3'b000;
    pc_src       = 2'b00;
    muldiv_start = 1'b0;
    fault        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b10;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_type  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = r_wb_sel;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        imm_type  = 3'b010;
        pc_src    = 2'b01;
        pc_write  = branch_taken;
      end
      S_JUMP: begin
        alu_src_b = 2'b01;
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        if (opcode == OP_JAL) begin
          alu_src_a = 2'b10;
          imm_type  = 3'b100;
        end else begin
          alu_src_a = 2'b01;
        end
      end
      S_UPPER: begin
        alu_src_b = 2'b01;
        imm_type  = 3'b011;
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b10;
      end
`ifdef MULTICYCLE_MULDIV_EN
      S_MULDIV: muldiv_start = !r_md_busy;
`endif
      S_FAULT:  fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control (MEM_TIMEOUT = 4). Expected output
// vectors are pushed to a scoreboard queue as each cycle's stimulus is
// applied and popped/compared once the outputs have settled.
module tb_multicycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       funct7_b0, branch_taken, mem_ready, muldiv_done;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op, pc_src;
  logic [2:0] imm_type;
  logic       muldiv_start, fault;
  logic [3:0] state;

  logic [24:0] obs;
  logic [24:0] exp_v;
  logic [24:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_b0(funct7_b0),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_type(imm_type), .pc_src(pc_src),
    .muldiv_start(muldiv_start), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, imm_type, pc_src,
                muldiv_start, fault};

  // Reference output table: expected outputs for a given state and inputs.
  function automatic logic [24:0] exp_vec(input int st, input logic [6:0] op,
                                          input logic bt, input logic mr,
                                          input logic [1:0] wbl, input logic ms);
    logic pcw, irw, mrd, mwr, iod, rw, flt;
    logic [1:0] wb, a, b, aop, pcs;
    logic [2:0] imm;
    {pcw, irw, mrd, mwr, iod, rw, flt} = '0;
    {wb, a, b, aop, pcs} = '0;
    imm = '0;
    case (st)
      1:  begin mrd = 1; b = 2'b10; pcw = mr; irw = mr; end
      3:  begin a = 2'b01; aop = 2'b10; end
      4:  begin a = 2'b01; b = 2'b01; aop = 2'b11; end
      5:  begin a = 2'b01; b = 2'b01; imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
      6:  begin mrd = 1; iod = 1; end
      7:  begin mwr = 1; iod = 1; end
      8:  begin rw = 1; wb = wbl; end
      9:  begin a = 2'b01; aop = 2'b01; imm = 3'b010; pcs = 2'b01; pcw = bt; end
      10: begin
        b = 2'b01; pcs = 2'b10; pcw = 1; rw = 1; wb = 2'b10;
        if (op == OP_JAL) begin a = 2'b10; imm = 3'b100; end
        else a = 2'b01;
      end
      11: begin b = 2'b01; imm = 3'b011; a = (op == OP_LUI) ? 2'b11 : 2'b10; end
      15: flt = 1;
      default: ;
    endcase
    return {4'(st), pcw, irw, mrd, mwr, iod, rw, wb, a, b, aop, imm, pcs,
            (st == 12) ? ms : 1'b0, flt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic f7, input logic bt,
                        input logic mr, input logic md);
    opcode = op; funct7_b0 = f7; branch_taken = bt; mem_ready = mr; muldiv_done = md;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(7'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1);
      sb.push_back(25'd0);
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  // ADD with zero-wait memory: IDLE, FETCH, DECODE, EXEC_R, WB.
  task automatic test_add();
    int st[5];
    int pcw_cnt = 0;
    st = '{0, 1, 2, 3, 8};
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(OP_R, 1'b0, 1'b0, 1'b1, 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL add[%0d]: got %h required %h", i, obs, exp_v);
      end
      pcw_cnt += int'(pc_write);
      tick();
    end
    n_checks++;
    if (pcw_cnt !== 1) begin
      n_fail++; $display("FAIL add_pc_write_count: got %0d required 1", pcw_cnt);
    end
  endtask

  // LW: 3 FETCH waits, 2 MEM_RD waits -> 10 cycles, wb_sel=01.
  task automatic test_load();
    int st[10];
    logic mr[10];
    int irw_cnt = 0;
    st = '{1, 1, 1, 1, 2, 5, 6, 6, 6, 8};
    mr = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      set_in(OP_LOAD, 1'b0, 1'b0, mr[i], 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b01, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL load[%0d]: got %h required %h", i, obs, exp_v);
      end
      irw_cnt += int'(ir_write);
      tick();
    end
    n_checks++;
    if (irw_cnt !== 1) begin
      n_fail++; $display("FAIL load_ir_write_count: got %0d required 1", irw_cnt);
    end
  endtask

  task automatic test_store();
    int st[5];
    logic mr[5];
    st = '{1, 2, 5, 7, 7};
    mr = '{1, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      set_in(OP_STORE, 1'b0, 1'b0, mr[i], 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL store[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  // BEQ not taken, then taken.
  task automatic test_branch();
    int st[6];
    logic bt[6];
    st = '{1, 2, 9, 1, 2, 9};
    bt = '{1, 1, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      set_in(OP_BRANCH, 1'b0, bt[i], 1'b1, 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL branch[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  // JAL, JALR, LUI, AUIPC, ADDI with zero-wait fetch.
  task automatic test_other_types();
    logic [6:0] ops[5];
    int seq[5][4];
    int len[5];
    ops = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_IMM};
    seq = '{'{1, 2, 10, 0}, '{1, 2, 10, 0}, '{1, 2, 11, 8}, '{1, 2, 11, 8}, '{1, 2, 4, 8}};
    len = '{3, 3, 4, 4, 4};
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < len[k]; i++) begin
        set_in(ops[k], 1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back(exp_vec(seq[k][i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
        #1;
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL types[%0d][%0d]: got %h required %h", k, i, obs, exp_v);
        end
        tick();
      end
    end
  endtask

  // mem_ready arrives on the 5th FETCH cycle, exactly at the timeout limit.
  task automatic test_timeout_complete();
    int st[8];
    logic mr[8];
    st = '{1, 1, 1, 1, 1, 2, 4, 8};
    mr = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      set_in(OP_IMM, 1'b0, 1'b0, mr[i], 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL timeout_complete[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
`ifdef MULTICYCLE_MULDIV_EN
    int st[6];
    logic md[6];
    logic ms[6];
    int start_cnt = 0;
    st = '{1, 2, 12, 12, 12, 8};
    md = '{0, 0, 0, 0, 1, 0};
    ms = '{0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      set_in(OP_R, 1'b1, 1'b0, 1'b1, md[i]);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, ms[i]));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL muldiv[%0d]: got %h required %h", i, obs, exp_v);
      end
      start_cnt += int'(muldiv_start);
      tick();
    end
    n_checks++;
    if (start_cnt !== 1) begin
      n_fail++; $display("FAIL muldiv_start_count: got %0d required 1", start_cnt);
    end
`else
    int st[4];
    st = '{1, 2, 15, 15};
    for (int i = 0; i < 4; i++) begin
      set_in(OP_R, 1'b1, 1'b0, 1'b1, 1'b1);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL muldiv_fault[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
`endif
  endtask

  // Illegal opcode faults after DECODE; asynchronous reset clears fault.
  task automatic test_illegal();
    int st[6];
    logic mr[6];
    st = '{0, 1, 2, 15, 15, 15};
    mr = '{1, 1, 0, 1, 0, 1};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(7'b0000000, 1'b0, 1'b1, mr[i], 1'b1);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL illegal[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    sb.push_back(25'd0);
    #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL illegal_async_clear: got %h required %h", obs, exp_v);
    end
    tick();
  endtask

  // mem_ready never arrives in FETCH: FAULT after 5 FETCH cycles, sticky.
  task automatic test_fetch_timeout();
    int st[9];
    logic mr[9];
    st = '{0, 1, 1, 1, 1, 1, 15, 15, 15};
    mr = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_in(OP_R, 1'b0, 1'b0, mr[i], 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL fetch_timeout[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
    rst_n = 1'b0;
    sb.push_back(25'd0);
    #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fetch_timeout_reset: got %h required %h", obs, exp_v);
    end
    tick();
  endtask

  // Reset during MEM_RD aborts at once; release cycle drives no request.
  task automatic test_reset_abort();
    int st[8];
    logic mr[8];
    logic rs[8];
    st = '{0, 1, 2, 5, 6, 0, 0, 1};
    mr = '{1, 1, 1, 1, 0, 1, 1, 1};
    rs = '{1, 1, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      rst_n = rs[i];
      set_in(OP_LOAD, 1'b0, 1'b0, mr[i], 1'b0);
      sb.push_back(exp_vec(st[i], opcode, branch_taken, mem_ready, 2'b00, 1'b0));
      #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset_abort[%0d]: got %h required %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_other_types();
    test_timeout_complete();
    test_muldiv();
    test_illegal();
    test_fetch_timeout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle main decoder. A Moore state machine sequences each RV32I instruction through fetch, decode, execute, memory and write-back steps. It drives a shared-memory multi-cycle datapath and waits on a ready handshake for every memory access. It also adds a memory-timeout and illegal-opcode fault state that the single-cycle decoder does not have.

## Interface
- MEM_TIMEOUT, 255: max wait cycles on mem_ready/muldiv_done before FAULT; 0 disables timeout
- CNT_W, $clog2(MEM_TIMEOUT+1) (min 1): wait-counter width, derived
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from IR
- funct7_b0  in  1  instruction[25] from IR
- branch_taken  in  1  comparator result for the current branch
- mem_ready  in  1  memory completes current access this cycle
- muldiv_done  in  1  mul/div unit result valid
- pc_write  out  1  load PC
- ir_write  out  1  load IR and old_pc
- mem_read, mem_write  out  1 each  memory request
- i_or_d  out  1  address select: 0=PC, 1=ALU register
- reg_write  out  1  register file write
- wb_sel  out  2  00=ALU reg, 01=MDR, 10=PC (already +4)
- alu_src_a  out  2  00=PC, 01=rs1, 10=old_pc, 11=zero
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_op  out  2  00=add, 01=branch, 10=R-type, 11=I-type
- imm_type  out  3  000=I, 001=S, 010=B, 011=U, 100=J
- pc_src  out  2  00=ALU result (PC+4), 01=branch target, 10=ALU result (jump)
- muldiv_start  out  1  one-cycle start pulse
- fault  out  1  sticky fault flag
- state  out  4  current state encoding (debug)

## Operation
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7
  - WB=8, BRANCH=9, JUMP=10, UPPER=11, MULDIV=12, FAULT=15
- Outputs are a combinational function of the state register, plus mem_ready/branch_taken where noted. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH, unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=10, pc_src=00. When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: one cycle, dispatches on opcode:
  - 0110011 goes to EXEC_R, or to MULDIV if funct7_b0=1
  - 0010011 goes to EXEC_I
  - 0000011 and 0100011 go to MEM_ADDR
  - 1100011 goes to BRANCH
  - 1101111 and 1100111 go to JUMP
  - 0110111 and 0010111 go to UPPER
  - any other opcode goes to FAULT
- EXEC_R: a=01, b=00, alu_op=10. Next state WB, with wb_sel=00 latched.
- EXEC_I: a=01, b=01, alu_op=11, imm=000. Next state WB, with wb_sel=00 latched.
- MEM_ADDR: a=01, b=01, alu_op=00, imm=000 (load) or 001 (store). Next state MEM_RD or MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. When mem_ready=1, next state WB with wb_sel=01 latched.
- MEM_WR: mem_write=1, i_or_d=1. When mem_ready=1, next state FETCH.
- BRANCH: a=01, b=00, alu_op=01, imm=010, pc_src=01, pc_write=branch_taken. Next state FETCH.
- JUMP:
  - Common: b=01, pc_src=10, pc_write=1, reg_write=1, wb_sel=10.
  - JAL: a=10, imm=100. JALR: a=01, imm=000.
  - Next state FETCH.
- UPPER: b=01, imm=011, alu_op=00; a=11 for LUI, 10 for AUIPC. Next state WB, with wb_sel=00 latched.
- WB: reg_write=1, wb_sel=the latched value. Next state FETCH.
- FAULT: fault=1 and all other outputs 0. Only exited by reset.
- Opcode for the MEM_ADDR/JUMP/UPPER sub-selects is taken from the IR; the IR is stable after FETCH.

## Timing
- Reset (asynchronous): state=IDLE, wait counter=0, latched wb_sel=00. All outputs are 0 while rst_n=0, including fault.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEM_RD, MEM_WR or MULDIV without completion.
  - If it equals MEM_TIMEOUT (and MEM_TIMEOUT≠0) with no completion that cycle, next state is FAULT.
  - Completion wins over timeout in the same cycle.
- Zero-wait handshake: mem_ready=1 in the first cycle of a request completes that request in that cycle.
- Requests hold stable until completion.
- Cycles per instruction with zero wait:
  - R/I/LUI/AUIPC: 4
  - Load: 5
  - Store: 4
  - Branch/JAL/JALR: 3
- Reset asserted mid-instruction aborts immediately. No memory request is driven on the reset-release cycle.

## Configuration
- MULTICYCLE_MULDIV_EN defined:
  - R-type with funct7_b0=1 enters MULDIV.
  - muldiv_start=1 in the first MULDIV cycle only.
  - The state waits for muldiv_done (with timeout), then goes to WB with wb_sel=00.
- Undefined:
  - The MULDIV state is absent and muldiv_start is tied 0.
  - R-type with funct7_b0=1 goes to FAULT.

## Test plan
- Reset, then ADD (0110011) with mem_ready always 1 → state sequence 0,1,2,3,8,1; reg_write high only in WB; pc_write once.
- LW with mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD → mem_read held throughout, ir_write exactly once; WB has wb_sel=01; 10 cycles total.
- BEQ with branch_taken=0 and then =1 → pc_write 0 and 1 respectively in BRANCH, pc_src=01; returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → FAULT entered after 5 FETCH cycles; fault=1 until rst_n low; asserting mem_ready on the 5th cycle instead completes the fetch.
- opcode 0000000 → DECODE then FAULT; state=15, all enables 0.
- funct7_b0=1 R-type: with macro, muldiv_start pulses once and WB follows muldiv_done; without macro, goes to FAULT.
